decimation_stream: RTL
======================

Name: decimation_stream

Overview:
- Streaming 2x nearest-neighbour downscaler for 8-bit greyscale frames; the inverse of the ALU's 2x pixel-replication path.
- Consumes 64-bit words (8 pixels, MSB pixel first) and emits 32-bit words (4 pixels).
- Keeps even-indexed pixels of every even row and drops odd rows entirely.
- Sits between the frame source / memory reader and the ALU output buffer, using valid/ready handshakes on both sides.

Parameters:
- IMG_WIDTH, 320, input row width in pixels; must be a multiple of 8.
- IMG_HEIGHT, 240, input frame height in rows; must be ≥1.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  in_data/in_sof valid
- in_ready  output  1  block accepts the input word this cycle
- in_data  input  64  8 pixels; pixel0=[63:56] … pixel7=[7:0]
- in_sof  input  1  marks the first word of a frame
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts the output word
- out_data  output  32  4 pixels; pixel0=[31:24] … pixel3=[7:0]
- out_sof  output  1  first output word of a frame; qualified by out_valid
- out_eol  output  1  last output word of a kept row; qualified by out_valid
- frame_done  output  1  one-cycle pulse after the last input word of a frame is accepted

Behaviour:
- Reset (async, active-high) clears all state:
  - state=IDLE; col and row counters =0.
  - out_valid=0, out_data=0, out_sof=0, out_eol=0, frame_done=0.
- Counters:
  - WPR = IMG_WIDTH/8 words per row.
  - col counter 0..WPR-1, width $clog2(WPR) (minimum 1 bit).
  - row counter 0..IMG_HEIGHT-1, width $clog2(IMG_HEIGHT) (minimum 1 bit).
- Transfer rules:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- States:
  - IDLE: in_ready=1; words without in_sof are discarded. A transfer with in_sof → processed as row0 col0, next state KEEP.
  - KEEP (even row): in_ready = !out_valid | out_ready (single output register, no bubble under continuous flow).
    - Each transfer loads the output register next cycle: out_data = {in[63:56], in[47:40], in[31:24], in[15:8]}.
    - out_sof=1 for row0 col0; out_eol=1 when col=WPR-1.
  - DROP (odd row): in_ready=1; words are consumed, no output is produced.
- Latency: kept word → out_valid one cycle after the input transfer.
- The output register holds its value while out_valid & !out_ready.
- End of row (col=WPR-1 transfer): col←0, row++; next state KEEP if the new row is even, DROP if odd.
- End of frame (transfer at col=WPR-1, row=IMG_HEIGHT-1):
  - row←0; next state IDLE.
  - frame_done=1 in the next cycle only.
  - An odd IMG_HEIGHT means the last row is kept.
- in_sof mid-frame (KEEP or DROP, on a transfer): resync.
  - Counters are forced so that word becomes row0 col0; it is kept and tagged out_sof.
  - No frame_done is issued for the aborted frame.
- out_valid clears after an output transfer unless a new word loads in the same cycle (simultaneous load and drain allowed).
- Reset mid-frame discards any pending output word immediately.

Optional Feature:
- Macro: DECIMATION_AVG_EN.
- Defined: each output pixel is the rounded mean of its horizontal pair, (a+b+1)>>1 computed in 9 bits; e.g. 0x10,0x13 → 0x12.
  - Row dropping, timing and latency are unchanged.
- Undefined: pure decimation (even pixel of each pair); no adder logic is synthesized.

Test Plan (IMG_WIDTH=16, IMG_HEIGHT=4 unless stated):
- Reset then frame of 8 words, in_data=0x0011223344556677 on every word, out_ready=1 → 4 outputs (rows 0 and 2), each 0x00224466; out_sof on the 1st; out_eol on the 2nd and 4th; frame_done exactly 1 cycle after the 8th input transfer.
- Same frame with out_ready=0 for 5 cycles at the 1st output → out_data holds 0x00224466; in_ready=0 in KEEP while stalled; in_ready=1 through DROP words; no loss or duplication.
- Words without in_sof while IDLE (0xFFFF…) → no output, in_ready=1; a following sof word 0x8081828384858687 → output 0x80828486 with out_sof=1.
- in_sof asserted on row1 col1 mid-frame → that word is output with out_sof=1, counters restart, no frame_done for the aborted frame.
- Reset asserted while out_valid=1 → out_valid=0 asynchronously; after release, state is IDLE.
- IMG_HEIGHT=3 with DECIMATION_AVG_EN defined, data 0x1013FF00020440C0 → outputs 0x12800380 for rows 0 and 2; frame_done after 6 words.

Source files
------------

// File: rtl/decimation_stream.sv
// decimation_stream: 2x nearest-neighbour downscaler for 8-bit greyscale frames.
// Takes 64-bit words (8 pixels, MSB pixel first) and emits 32-bit words (4 pixels).
// Keeps the even pixel of each horizontal pair on even rows and drops odd rows.
// Build option: define DECIMATION_AVG_EN to emit the rounded mean of each pair
// instead of the even pixel.
module decimation_stream #(
    parameter int IMG_WIDTH  = 320,  // input row width in pixels, multiple of 8
    parameter int IMG_HEIGHT = 240   // input frame height in rows, >= 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic        in_sof,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_sof,
    output logic        out_eol,
    output logic        frame_done
);

    localparam int WPR   = IMG_WIDTH / 8;
    localparam int COL_W = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WPR - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE,
        KEEP,
        DROP
    } state_e;

    state_e            state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_data_q, out_data_d;
    logic              out_sof_q, out_sof_d;
    logic              out_eol_q, out_eol_d;
    logic              frame_done_q, frame_done_d;

    logic              out_free;
    logic              accept;
    logic              keep;
    logic [COL_W-1:0]  cur_col;
    logic [ROW_W-1:0]  cur_row;
    logic [ROW_W-1:0]  next_row;
    logic [31:0]       kept_pixels;

`ifdef DECIMATION_AVG_EN
    // Rounded mean of a horizontal pixel pair; the 9-bit sum keeps the carry.
    function automatic logic [7:0] pair_avg(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b} + 9'd1;
        return sum[8:1];
    endfunction

    assign kept_pixels = {pair_avg(in_data[63:56], in_data[55:48]),
                          pair_avg(in_data[47:40], in_data[39:32]),
                          pair_avg(in_data[31:24], in_data[23:16]),
                          pair_avg(in_data[15:8],  in_data[7:0])};
`else
    logic unused_odd_pixels;

    assign kept_pixels = {in_data[63:56], in_data[47:40], in_data[31:24], in_data[15:8]};
    // Odd pixels are intentionally discarded in pure decimation.
    assign unused_odd_pixels = ^{in_data[55:48], in_data[39:32], in_data[23:16], in_data[7:0]};
`endif

    // The single output register can take a new word when empty or draining.
    assign out_free = !out_valid_q || out_ready;

    // Handshake, frame position tracking and output register next-state.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        in_ready     = 1'b0;
        accept       = 1'b0;
        cur_col      = col_q;
        cur_row      = row_q;
        next_row     = row_q + ROW_W'(1);
        frame_done_d = 1'b0;
        out_valid_d  = out_valid_q && !out_ready;
        out_data_d   = out_data_q;
        out_sof_d    = out_sof_q;
        out_eol_d    = out_eol_q;

        // A start-of-frame word always becomes a kept word, so in IDLE and DROP
        // it must wait for space in the output register like a KEEP word does.
        case (state_q)
            IDLE: begin
                in_ready = !(in_valid && in_sof) || out_free;
                accept   = in_valid && in_ready && in_sof;
            end
            KEEP: begin
                in_ready = out_free;
                accept   = in_valid && in_ready;
            end
            DROP: begin
                in_ready = !(in_valid && in_sof) || out_free;
                accept   = in_valid && in_ready;
            end
            default: state_d = IDLE;
        endcase

        // Start of frame (including a mid-frame resync) restarts at row 0, col 0.
        if (accept && in_sof) begin
            cur_col = '0;
            cur_row = '0;
        end
        next_row = cur_row + ROW_W'(1);
        keep     = accept && (in_sof || (state_q == KEEP));

        if (accept) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                if (cur_row == ROW_LAST) begin
                    row_d        = '0;
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end else begin
                    row_d   = next_row;
                    state_d = next_row[0] ? DROP : KEEP;
                end
            end else begin
                col_d   = cur_col + COL_W'(1);
                row_d   = cur_row;
                state_d = (state_q == IDLE) ? KEEP : (in_sof ? KEEP : state_q);
            end
        end

        if (keep) begin
            out_valid_d = 1'b1;
            out_data_d  = kept_pixels;
            out_sof_d   = (cur_row == '0) && (cur_col == '0);
            out_eol_d   = (cur_col == COL_LAST);
        end
    end

    // State, counters and output register; reset drops any pending output word.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_sof_q    <= 1'b0;
            out_eol_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sof_q    <= out_sof_d;
            out_eol_q    <= out_eol_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_sof    = out_sof_q;
    assign out_eol    = out_eol_q;
    assign frame_done = frame_done_q;

endmodule
